// File: rtl/mips_ctrl_pkg.sv
// Shared definitions for the multicycle MIPS control path.
// Contents:
//   state_t        - main control FSM state encodings (also visible on the
//                    State debug port)
//   OP_*           - opcode field values (IR[31:26]) recognised by the FSM
//   SRCB_*         - ALU operand-B mux select encodings
//   ALUOP_*        - ALU control request encodings
//   PCSRC_*        - PC source mux select encodings
//   dispatch_state - DECODE-state dispatch on opcode
package mips_ctrl_pkg;

    typedef enum logic [3:0] {
        S_RST    = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_MEMADR = 4'd3,
        S_MEMRD  = 4'd4,
        S_MEMWB  = 4'd5,
        S_MEMWR  = 4'd6,
        S_REXEC  = 4'd7,
        S_RWB    = 4'd8,
        S_BRANCH = 4'd9,
        S_JUMP   = 4'd10,
        S_ADDIEX = 4'd11,
        S_ADDIWB = 4'd12,
        S_EXC    = 4'd13
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    localparam logic [1:0] SRCB_B       = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;
    localparam logic [1:0] PCSRC_EXC    = 2'b11;

    // Where DECODE goes for a given opcode; anything unrecognised traps.
    function automatic state_t dispatch_state(input logic [5:0] op);
        case (op)
            OP_LW, OP_SW: dispatch_state = S_MEMADR;
            OP_RTYPE:     dispatch_state = S_REXEC;
            OP_BEQ:       dispatch_state = S_BRANCH;
            OP_J:         dispatch_state = S_JUMP;
            OP_ADDI:      dispatch_state = S_ADDIEX;
            default:      dispatch_state = S_EXC;
        endcase
    endfunction

endpackage

// File: rtl/mem_wait_counter.sv
// Memory wait-state counter.
// Counts 0..MEM_LATENCY-1 while 'active' is high and flags the final cycle.
// The count returns to zero on the last cycle (the owning state exits then)
// and whenever 'active' is low, so every memory state starts from zero.
// Ports:
//   clk    - system clock, rising edge
//   reset  - synchronous, active-low
//   active - current state is a memory-access state
//   last   - count has reached MEM_LATENCY-1
module mem_wait_counter #(
    parameter int MEM_LATENCY = 1,
    parameter int CNT_W       = $clog2(MEM_LATENCY + 1)
) (
    input  logic clk,
    input  logic reset,
    input  logic active,
    output logic last
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MEM_LATENCY - 1);

    logic [CNT_W-1:0] count;

    assign last = (count == LAST_CNT);

    always_ff @(posedge clk) begin
        if (!reset) begin
            count <= '0;
        end else if (!active || last) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/main_control_fsm.sv
// Multicycle MIPS main control unit (Moore FSM).
// Sequences fetch/decode/execute/memory/writeback and drives every datapath
// select and enable. Outputs decode only the state and the wait-counter
// last-cycle flag; Opcode feeds next-state logic only.
//
// state  | meaning
// -------+------------------------------------------------------------
// RST    | reset; all outputs low
// FETCH  | read instruction at PC, PC+4 in ALU; IR/PC load on last cycle
// DECODE | branch target (PC + imm<<2) into ALUOut; dispatch on opcode
// MEMADR | effective address A + imm
// MEMRD  | load read at ALUOut for MEM_LATENCY cycles
// MEMWB  | write MDR to rt
// MEMWR  | store at ALUOut; single write pulse on last cycle
// REXEC  | R-type ALU op (funct decoded)
// RWB    | write ALUOut to rd
// BRANCH | A - B; PC <= ALUOut when Zero
// JUMP   | PC <= jump target
// ADDIEX | A + imm
// ADDIWB | write ALUOut to rt
// EXC    | undefined opcode; PC <= exception vector, IllegalOp latched
//
// Ports:
//   clk, reset (sync active-low), Opcode = IR[31:26]
//   PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
//   RegDst, RegWrite, ALUSrcA, ALUSrcB[1:0], ALUOp[1:0], PCSource[1:0]
//   IllegalOp (sticky until reset), State[3:0] (debug)
module main_control_fsm
    import mips_ctrl_pkg::*;
#(
    parameter int MEM_LATENCY = 1,
    parameter int CNT_W       = $clog2(MEM_LATENCY + 1)
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] Opcode,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       MemtoReg,
    output logic       RegDst,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic [1:0] PCSource,
    output logic       IllegalOp,
    output logic [3:0] State
);

    state_t state_q;
    state_t state_next;
    logic   mem_active;
    logic   mem_last;
    logic   illegal_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= S_RST;
            illegal_q <= 1'b0;
        end else begin
            state_q <= state_next;
            if (state_q == S_EXC) begin
                illegal_q <= 1'b1;
            end
        end
    end

    assign mem_active = (state_q == S_FETCH) || (state_q == S_MEMRD) ||
                        (state_q == S_MEMWR);

    mem_wait_counter #(
        .MEM_LATENCY (MEM_LATENCY),
        .CNT_W       (CNT_W)
    ) u_wait (
        .clk    (clk),
        .reset  (reset),
        .active (mem_active),
        .last   (mem_last)
    );

    always_comb begin
        state_next  = S_RST;
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        MemtoReg    = 1'b0;
        RegDst      = 1'b0;
        RegWrite    = 1'b0;
        ALUSrcA     = 1'b0;
        ALUSrcB     = SRCB_B;
        ALUOp       = ALUOP_ADD;
        PCSource    = PCSRC_ALU;

        case (state_q)
            S_RST: begin
                state_next = S_FETCH;
            end
            S_FETCH: begin
                MemRead = 1'b1;
                ALUSrcB = SRCB_FOUR;
                // IR and PC load only once the read data is valid.
                if (mem_last) begin
                    IRWrite    = 1'b1;
                    PCWrite    = 1'b1;
                    state_next = S_DECODE;
                end else begin
                    state_next = S_FETCH;
                end
            end
            S_DECODE: begin
                ALUSrcB    = SRCB_IMM_SH2;
                state_next = dispatch_state(Opcode);
            end
            S_MEMADR: begin
                ALUSrcA    = 1'b1;
                ALUSrcB    = SRCB_IMM;
                state_next = (Opcode == OP_SW) ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                MemRead    = 1'b1;
                IorD       = 1'b1;
                state_next = mem_last ? S_MEMWB : S_MEMRD;
            end
            S_MEMWB: begin
                RegWrite   = 1'b1;
                MemtoReg   = 1'b1;
                state_next = S_FETCH;
            end
            S_MEMWR: begin
                IorD = 1'b1;
                if (mem_last) begin
                    MemWrite   = 1'b1;
                    state_next = S_FETCH;
                end else begin
                    state_next = S_MEMWR;
                end
            end
            S_REXEC: begin
                ALUSrcA    = 1'b1;
                ALUOp      = ALUOP_FUNCT;
                state_next = S_RWB;
            end
            S_RWB: begin
                RegWrite   = 1'b1;
                RegDst     = 1'b1;
                state_next = S_FETCH;
            end
            S_BRANCH: begin
                ALUSrcA     = 1'b1;
                ALUOp       = ALUOP_SUB;
                PCWriteCond = 1'b1;
                PCSource    = PCSRC_ALUOUT;
                state_next  = S_FETCH;
            end
            S_JUMP: begin
                PCWrite    = 1'b1;
                PCSource   = PCSRC_JUMP;
                state_next = S_FETCH;
            end
            S_ADDIEX: begin
                ALUSrcA    = 1'b1;
                ALUSrcB    = SRCB_IMM;
                state_next = S_ADDIWB;
            end
            S_ADDIWB: begin
                RegWrite   = 1'b1;
                state_next = S_FETCH;
            end
            S_EXC: begin
                PCWrite    = 1'b1;
                PCSource   = PCSRC_EXC;
                state_next = S_FETCH;
            end
            default: begin
                state_next = S_RST;
            end
        endcase
    end

    // Visible during EXC itself, then held by the sticky register.
    assign IllegalOp = illegal_q | (state_q == S_EXC);
    assign State     = state_q;

endmodule

// File: tb/tb_main_control_fsm.sv
// Directed bench for main_control_fsm: one instance at MEM_LATENCY=1 and one
// at MEM_LATENCY=3. Every output is packed into a 21-bit control word
// {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst,
//  RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource, IllegalOp, State}
// and compared against hand-written expected words on the falling edge.
module tb_main_control_fsm;

    localparam logic [5:0] OPC_R    = 6'b000000;
    localparam logic [5:0] OPC_LW   = 6'b100011;
    localparam logic [5:0] OPC_SW   = 6'b101011;
    localparam logic [5:0] OPC_BEQ  = 6'b000100;
    localparam logic [5:0] OPC_J    = 6'b000010;
    localparam logic [5:0] OPC_ADDI = 6'b001000;
    localparam logic [5:0] OPC_BAD  = 6'b111111;

    //                              flags          SrcB   ALUOp  PCSrc  Ill   State
    localparam logic [20:0] W_RST       = 21'd0;
    localparam logic [20:0] W_FETCH_L   = {10'b1001010000, 2'b01, 2'b00, 2'b00, 1'b0, 4'd1};
    localparam logic [20:0] W_FETCH_W   = {10'b0001000000, 2'b01, 2'b00, 2'b00, 1'b0, 4'd1};
    localparam logic [20:0] W_DECODE    = {10'b0000000000, 2'b11, 2'b00, 2'b00, 1'b0, 4'd2};
    localparam logic [20:0] W_MEMADR    = {10'b0000000001, 2'b10, 2'b00, 2'b00, 1'b0, 4'd3};
    localparam logic [20:0] W_MEMRD     = {10'b0011000000, 2'b00, 2'b00, 2'b00, 1'b0, 4'd4};
    localparam logic [20:0] W_MEMWB     = {10'b0000001010, 2'b00, 2'b00, 2'b00, 1'b0, 4'd5};
    localparam logic [20:0] W_MEMWR_W   = {10'b0010000000, 2'b00, 2'b00, 2'b00, 1'b0, 4'd6};
    localparam logic [20:0] W_MEMWR_L   = {10'b0010100000, 2'b00, 2'b00, 2'b00, 1'b0, 4'd6};
    localparam logic [20:0] W_REXEC     = {10'b0000000001, 2'b00, 2'b10, 2'b00, 1'b0, 4'd7};
    localparam logic [20:0] W_RWB       = {10'b0000000110, 2'b00, 2'b00, 2'b00, 1'b0, 4'd8};
    localparam logic [20:0] W_BRANCH    = {10'b0100000001, 2'b00, 2'b01, 2'b01, 1'b0, 4'd9};
    localparam logic [20:0] W_JUMP      = {10'b1000000000, 2'b00, 2'b00, 2'b10, 1'b0, 4'd10};
    localparam logic [20:0] W_ADDIEX    = {10'b0000000001, 2'b10, 2'b00, 2'b00, 1'b0, 4'd11};
    localparam logic [20:0] W_ADDIWB    = {10'b0000000010, 2'b00, 2'b00, 2'b00, 1'b0, 4'd12};
    localparam logic [20:0] W_EXC       = {10'b1000000000, 2'b00, 2'b00, 2'b11, 1'b1, 4'd13};
    localparam logic [20:0] ILL         = 21'h10;

    logic       clk;
    logic       rst1, rst3;
    logic [5:0] op1, op3;

    logic       pcw1, pcwc1, iord1, mr1, mw1, irw1, m2r1, rd1, rw1, srca1, ill1;
    logic [1:0] srcb1, aluop1, pcs1;
    logic [3:0] st1;
    logic       pcw3, pcwc3, iord3, mr3, mw3, irw3, m2r3, rd3, rw3, srca3, ill3;
    logic [1:0] srcb3, aluop3, pcs3;
    logic [3:0] st3;

    logic [20:0] ctl1, ctl3;

    int tests_run;
    int tests_failed;

    assign ctl1 = {pcw1, pcwc1, iord1, mr1, mw1, irw1, m2r1, rd1, rw1, srca1,
                   srcb1, aluop1, pcs1, ill1, st1};
    assign ctl3 = {pcw3, pcwc3, iord3, mr3, mw3, irw3, m2r3, rd3, rw3, srca3,
                   srcb3, aluop3, pcs3, ill3, st3};

    main_control_fsm #(.MEM_LATENCY(1)) u_dut1 (
        .clk(clk), .reset(rst1), .Opcode(op1),
        .PCWrite(pcw1), .PCWriteCond(pcwc1), .IorD(iord1), .MemRead(mr1),
        .MemWrite(mw1), .IRWrite(irw1), .MemtoReg(m2r1), .RegDst(rd1),
        .RegWrite(rw1), .ALUSrcA(srca1), .ALUSrcB(srcb1), .ALUOp(aluop1),
        .PCSource(pcs1), .IllegalOp(ill1), .State(st1)
    );

    main_control_fsm #(.MEM_LATENCY(3)) u_dut3 (
        .clk(clk), .reset(rst3), .Opcode(op3),
        .PCWrite(pcw3), .PCWriteCond(pcwc3), .IorD(iord3), .MemRead(mr3),
        .MemWrite(mw3), .IRWrite(irw3), .MemtoReg(m2r3), .RegDst(rd3),
        .RegWrite(rw3), .ALUSrcA(srca3), .ALUSrcB(srcb3), .ALUOp(aluop3),
        .PCSource(pcs3), .IllegalOp(ill3), .State(st3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Both instances held in reset; instance 1 released and runs a jump.
    task automatic test_reset();
        logic [20:0] exp [3];
        rst1 = 1'b0;
        rst3 = 1'b0;
        op1  = OPC_J;
        op3  = OPC_SW;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            tests_run++;
            if (ctl1 !== W_RST) begin
                tests_failed++;
                $display("FAIL reset_hold_l1 cycle %0d: got %b expected %b", i, ctl1, W_RST);
            end
            tests_run++;
            if (ctl3 !== W_RST) begin
                tests_failed++;
                $display("FAIL reset_hold_l3 cycle %0d: got %b expected %b", i, ctl3, W_RST);
            end
        end
        rst1 = 1'b1;
        exp[0] = W_FETCH_L;
        exp[1] = W_DECODE;
        exp[2] = W_JUMP;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            tests_run++;
            if (ctl1 !== exp[i]) begin
                tests_failed++;
                $display("FAIL reset_release_jump step %0d: got %b expected %b", i, ctl1, exp[i]);
            end
        end
    endtask

    task automatic test_lw();
        logic [20:0] exp [5];
        op1 = OPC_LW;
        exp[0] = W_FETCH_L;
        exp[1] = W_DECODE;
        exp[2] = W_MEMADR;
        exp[3] = W_MEMRD;
        exp[4] = W_MEMWB;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            tests_run++;
            if (ctl1 !== exp[i]) begin
                tests_failed++;
                $display("FAIL lw step %0d: got %b expected %b", i, ctl1, exp[i]);
            end
        end
    endtask

    task automatic test_beq();
        logic [20:0] exp [3];
        op1 = OPC_BEQ;
        exp[0] = W_FETCH_L;
        exp[1] = W_DECODE;
        exp[2] = W_BRANCH;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            tests_run++;
            if (ctl1 !== exp[i]) begin
                tests_failed++;
                $display("FAIL beq step %0d: got %b expected %b", i, ctl1, exp[i]);
            end
        end
    endtask

    task automatic test_addi();
        logic [20:0] exp [4];
        op1 = OPC_ADDI;
        exp[0] = W_FETCH_L;
        exp[1] = W_DECODE;
        exp[2] = W_ADDIEX;
        exp[3] = W_ADDIWB;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            tests_run++;
            if (ctl1 !== exp[i]) begin
                tests_failed++;
                $display("FAIL addi step %0d: got %b expected %b", i, ctl1, exp[i]);
            end
        end
    endtask

    task automatic test_illegal();
        logic [20:0] exp [3];
        op1 = OPC_BAD;
        exp[0] = W_FETCH_L;
        exp[1] = W_DECODE;
        exp[2] = W_EXC;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            tests_run++;
            if (ctl1 !== exp[i]) begin
                tests_failed++;
                $display("FAIL illegal step %0d: got %b expected %b", i, ctl1, exp[i]);
            end
        end
    endtask

    // Two back-to-back R-types after the trap; IllegalOp must stay set.
    task automatic test_back_to_back_rtype();
        logic [20:0] exp [4];
        op1 = OPC_R;
        exp[0] = W_FETCH_L | ILL;
        exp[1] = W_DECODE  | ILL;
        exp[2] = W_REXEC   | ILL;
        exp[3] = W_RWB     | ILL;
        for (int n = 0; n < 2; n++) begin
            for (int i = 0; i < 4; i++) begin
                @(negedge clk);
                tests_run++;
                if (ctl1 !== exp[i]) begin
                    tests_failed++;
                    $display("FAIL rtype_sticky instr %0d step %0d: got %b expected %b",
                             n, i, ctl1, exp[i]);
                end
            end
        end
    endtask

    task automatic test_reset_mid_memrd();
        logic [20:0] exp [4];
        op1 = OPC_LW;
        exp[0] = W_FETCH_L | ILL;
        exp[1] = W_DECODE  | ILL;
        exp[2] = W_MEMADR  | ILL;
        exp[3] = W_MEMRD   | ILL;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            tests_run++;
            if (ctl1 !== exp[i]) begin
                tests_failed++;
                $display("FAIL abort_lw step %0d: got %b expected %b", i, ctl1, exp[i]);
            end
        end
        rst1 = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            tests_run++;
            if (ctl1 !== W_RST) begin
                tests_failed++;
                $display("FAIL abort_reset cycle %0d: got %b expected %b", i, ctl1, W_RST);
            end
        end
        rst1 = 1'b1;
        @(negedge clk);
        tests_run++;
        if (ctl1 !== W_FETCH_L) begin
            tests_failed++;
            $display("FAIL abort_refetch: got %b expected %b", ctl1, W_FETCH_L);
        end
    endtask

    // Instance 3: store with wait states, 8 cycles, then the first fetch cycle.
    task automatic test_sw_lat3();
        logic [20:0] exp [9];
        rst3 = 1'b1;
        op3  = OPC_SW;
        exp[0] = W_FETCH_W;
        exp[1] = W_FETCH_W;
        exp[2] = W_FETCH_L;
        exp[3] = W_DECODE;
        exp[4] = W_MEMADR;
        exp[5] = W_MEMWR_W;
        exp[6] = W_MEMWR_W;
        exp[7] = W_MEMWR_L;
        exp[8] = W_FETCH_W;
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            tests_run++;
            if (ctl3 !== exp[i]) begin
                tests_failed++;
                $display("FAIL sw_lat3 step %0d: got %b expected %b", i, ctl3, exp[i]);
            end
        end
    endtask

    // Continues from the second fetch cycle left by the store above.
    task automatic test_lw_lat3();
        logic [20:0] exp [9];
        op3 = OPC_LW;
        exp[0] = W_FETCH_W;
        exp[1] = W_FETCH_L;
        exp[2] = W_DECODE;
        exp[3] = W_MEMADR;
        exp[4] = W_MEMRD;
        exp[5] = W_MEMRD;
        exp[6] = W_MEMRD;
        exp[7] = W_MEMWB;
        exp[8] = W_FETCH_W;
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            tests_run++;
            if (ctl3 !== exp[i]) begin
                tests_failed++;
                $display("FAIL lw_lat3 step %0d: got %b expected %b", i, ctl3, exp[i]);
            end
        end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst1 = 1'b0;
        rst3 = 1'b0;
        op1  = OPC_R;
        op3  = OPC_R;
        test_reset();
        test_lw();
        test_beq();
        test_addi();
        test_illegal();
        test_back_to_back_rtype();
        test_reset_mid_memrd();
        test_sw_lat3();
        test_lw_lat3();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/main_control_fsm.md
Name: main_control_fsm

Overview:
- Multicycle MIPS main control unit: Moore FSM sequencing fetch, decode, execute, memory and writeback for each instruction.
- Drives every datapath select and enable, including ALUSrcA, ALUSrcB (operand-B mux select) and ALUOp, PCSource and the register/memory write enables.
- Sits beside the datapath: consumes opcode bits from the instruction register, produces one control word per cycle.
- Supports configurable memory latency and traps undefined opcodes.

Parameters:
- MEM_LATENCY, 1, cycles each memory access holds (integer ≥1; 1 = no wait states).
- CNT_W, $clog2(MEM_LATENCY+1), width of the wait counter.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-low; sampled on rising clk.
- Opcode  input  6  IR[31:26].
- PCWrite  output  1  unconditional PC load.
- PCWriteCond  output  1  PC load gated by ALU Zero (beq).
- IorD  output  1  memory address select: 0 = PC, 1 = ALUOut.
- MemRead  output  1  memory read strobe.
- MemWrite  output  1  memory write strobe.
- IRWrite  output  1  instruction register load.
- MemtoReg  output  1  register write data: 0 = ALUOut, 1 = MDR.
- RegDst  output  1  destination register: 0 = rt, 1 = rd.
- RegWrite  output  1  register file write.
- ALUSrcA  output  1  ALU operand A: 0 = PC, 1 = A.
- ALUSrcB  output  2  ALU operand B: 00 = B, 01 = constant 4, 10 = sign-extended imm, 11 = sign-extended imm<<2.
- ALUOp  output  2  00 = add, 01 = sub, 10 = funct-decoded.
- PCSource  output  2  00 = ALU result, 01 = ALUOut, 10 = jump target, 11 = exception vector.
- IllegalOp  output  1  sticky flag, set on an undefined opcode.
- State  output  4  current state encoding, for debug.

Behaviour:
- Registered state and wait counter; all outputs are a combinational decode of state and counter only. Opcode affects only next-state logic.
- Opcodes: R = 000000, lw = 100011, sw = 101011, beq = 000100, j = 000010, addi = 001000. Any other opcode is illegal.
- Reset: reset=0 at a clk edge puts the FSM in RST, clears the counter and clears IllegalOp.
  - In RST all outputs are 0, except State = RST.
  - The cycle after reset returns to 1, the FSM enters FETCH.
  - Reset mid-instruction aborts it with no further write strobes.
- Outputs not listed for a state are 0. Transitions:
  - FETCH: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00. IRWrite and PCWrite are asserted only on the last latency cycle (counter = MEM_LATENCY-1); then go to DECODE.
  - DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=00 (branch target into ALUOut). Branch on Opcode:
    - lw/sw → MEMADR; R → REXEC; beq → BRANCH; j → JUMP; addi → ADDIEX.
    - Illegal → EXC.
  - MEMADR: ALUSrcA=1, ALUSrcB=10, ALUOp=00. Next is MEMRD for lw, MEMWR for sw (decided on Opcode held in IR).
  - MEMRD: MemRead=1, IorD=1, held MEM_LATENCY cycles; then MEMWB.
  - MEMWB: RegWrite=1, MemtoReg=1, RegDst=0; then FETCH.
  - MEMWR: IorD=1. MemWrite is asserted on the last latency cycle only (single write pulse); then FETCH.
  - REXEC: ALUSrcA=1, ALUSrcB=00, ALUOp=10; then RWB.
  - RWB: RegWrite=1, RegDst=1, MemtoReg=0; then FETCH.
  - BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=01; then FETCH.
  - JUMP: PCWrite=1, PCSource=10; then FETCH.
  - ADDIEX: ALUSrcA=1, ALUSrcB=10, ALUOp=00; then ADDIWB.
  - ADDIWB: RegWrite=1, RegDst=0, MemtoReg=0; then FETCH.
  - EXC: PCWrite=1, PCSource=11, IllegalOp set to 1 (it stays 1 until reset); then FETCH.
- Wait counter:
  - Counts 0..MEM_LATENCY-1 in FETCH, MEMRD and MEMWR only.
  - Cleared on every state exit; never wraps inside a state.
  - With MEM_LATENCY=1 each of these states lasts exactly 1 cycle.
- Cycle counts at MEM_LATENCY=1: lw 5, sw 4, R 4, addi 4, beq 3, j 3, illegal 3.
  - Each memory state adds MEM_LATENCY-1 cycles.
- Undefined state encodings return to RST on the next edge.

Decomposition:
- Shared package `mips_ctrl_pkg` holds:
  - state encodings;
  - opcode constants;
  - ALUSrcB, ALUOp and PCSource encodings, also used by the operand muxes and the ALU control.
- Optional sub-module `mem_wait_counter`: counter plus a last-cycle flag, parameterised by MEM_LATENCY.

Test Plan:
- Reset: hold reset=0 for 3 cycles, then release → all outputs 0 during reset. First cycle after release: State=FETCH, MemRead=1, ALUSrcB=01. At MEM_LATENCY=1, IRWrite=1 and PCWrite=1 in that same cycle.
- lw (Opcode=100011), MEM_LATENCY=1 → state sequence FETCH, DECODE, MEMADR, MEMRD, MEMWB. ALUSrcB sequence 01, 11, 10, 00, 00. RegWrite=1 with MemtoReg=1 in cycle 5 only.
- sw with MEM_LATENCY=3 → FETCH lasts 3 cycles with IRWrite only in the 3rd. MEMWR lasts 3 cycles with MemWrite only in the 3rd. Total 8 cycles.
- beq (000100) → in BRANCH: PCWriteCond=1, ALUOp=01, PCSource=01, ALUSrcB=00. Back in FETCH the next cycle.
- Illegal opcode 111111 → DECODE then EXC with PCSource=11, PCWrite=1. IllegalOp=1 and it persists through following R-type (000000, ALUOp=10 in REXEC) instructions.
- Assert reset=0 during MEMRD → next cycle in RST, MemRead=0, RegWrite never asserted, IllegalOp cleared.
